// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle multiply/divide freezes, plus a saturating stalled-cycle counter.
module hazard_control_unit #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rt1,
  input  logic        UsesRt1,
  input  logic        MemRead2,
  input  logic [4:0]  destreg2,
  input  logic        BranchTaken2,
  input  logic        MulDiv2,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        EXMEMBubble,
  output logic        MDBusy,
  output logic [15:0] StallCount
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   mdcnt, mdcntNext;
  logic               postMd, postMdNext;
  logic               loadUse;

  assign loadUse = MemRead2 && (destreg2 != 5'd0) &&
                   ((destreg2 == Rs1) || (UsesRt1 && (destreg2 == Rt1)));

  // State register; postMd masks the still-held mul/div for one RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      mdcnt  <= '0;
      postMd <= 1'b0;
    end else begin
      state  <= stateNext;
      mdcnt  <= mdcntNext;
      postMd <= postMdNext;
    end
  end

  // Next-state and hazard outputs
  always_comb begin
    stateNext   = state;
    mdcntNext   = mdcnt;
    postMdNext  = 1'b0;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    MDBusy      = 1'b0;

    unique case (state)
      RUN: begin
        if (MulDiv2 && !postMd) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
          stateNext   = MD_BUSY;
          mdcntNext   = CNT_W'(MD_LATENCY - 2);
        end else if (BranchTaken2) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
        end else if (loadUse) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      MD_BUSY: begin
        MDBusy      = 1'b1;
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMBubble = 1'b1;
        if (mdcnt == '0) begin
          stateNext  = RUN;
          postMdNext = 1'b1;
        end else begin
          mdcntNext = mdcnt - CNT_W'(1);
        end
      end
      default: stateNext = RUN;
    endcase

    // Reset forces a safe pipeline: everything held and bubbled
    if (rst) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      EXMEMBubble = 1'b1;
      MDBusy      = 1'b0;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (!PCWrite && (StallCount != {STALL_W{1'b1}})) begin
      StallCount <= StallCount + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1, Rt1, destreg2;
  logic        UsesRt1, MemRead2, BranchTaken2, MulDiv2;
  logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MDBusy;
  logic [15:0] StallCount;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;

  // Model: frozen cycles still owed to a mul/div, post-mul/div mask, stall total
  int mFreeze;
  bit mIgnore;
  int mStall;

  hazard_control_unit #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Rs1(Rs1), .Rt1(Rt1), .UsesRt1(UsesRt1),
    .MemRead2(MemRead2), .destreg2(destreg2), .BranchTaken2(BranchTaken2),
    .MulDiv2(MulDiv2), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEXWrite(IDEXWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
    .EXMEMBubble(EXMEMBubble), .MDBusy(MDBusy), .StallCount(StallCount)
  );

  // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MDBusy}
  assign outs = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble, EXMEMBubble, MDBusy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelLoadUse();
    if (!MemRead2 || destreg2 == 5'd0) return 1'b0;
    if (destreg2 == Rs1) return 1'b1;
    return UsesRt1 && (destreg2 == Rt1);
  endfunction

  function automatic logic [6:0] expOuts();
    if (rst)                      return 7'b000_111_0;
    if (mFreeze > 0)              return 7'b000_001_1;
    if (MulDiv2 && !mIgnore)      return 7'b000_001_0;
    if (BranchTaken2)             return 7'b111_110_0;
    if (modelLoadUse())           return 7'b001_010_0;
    return 7'b111_000_0;
  endfunction

  task automatic modelReset();
    mFreeze = 0;
    mIgnore = 1'b0;
    mStall  = 0;
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic mr, input logic [4:0] dr,
                       input logic bt, input logic md);
    @(negedge clk);
    rst = r; Rs1 = rs; Rt1 = rt; UsesRt1 = ut; MemRead2 = mr;
    destreg2 = dr; BranchTaken2 = bt; MulDiv2 = md;
    if (r) modelReset();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
  endtask

  // Advance one rising edge, stepping the model alongside
  task automatic tick();
    logic [6:0] e;
    int  nFreeze, nStall;
    bit  nIgnore;
    e = expOuts();
    nFreeze = mFreeze; nStall = mStall; nIgnore = 1'b0;
    if (rst) begin
      nFreeze = 0; nStall = 0;
    end else begin
      if (mFreeze > 0) begin
        nFreeze = mFreeze - 1;
        if (nFreeze == 0) nIgnore = 1'b1;
      end else if (MulDiv2 && !mIgnore) begin
        nFreeze = LAT - 1;
      end
      if (!e[6] && mStall < 65535) nStall = mStall + 1;
    end
    @(posedge clk);
    mFreeze = nFreeze; mIgnore = nIgnore; mStall = nStall;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (outs !== 7'b000_111_0) begin
      errors++; $display("FAIL reset_outs got=%b exp=%b", outs, 7'b000_111_0);
    end
    checks++;
    if (StallCount !== 16'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", StallCount);
    end
    tick();
    idle();
    checks++;
    if (outs !== 7'b111_000_0 || StallCount !== 16'd0) begin
      errors++; $display("FAIL reset_release got=%b/%0d exp=%b/0", outs, StallCount, 7'b111_000_0);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [15:0] s0;
    drive(1'b0, 5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    s0 = StallCount;
    checks++;
    if (outs !== 7'b001_010_0) begin
      errors++; $display("FAIL load_use_stall got=%b exp=%b", outs, 7'b001_010_0);
    end
    tick();
    idle();
    checks++;
    if (StallCount !== s0 + 16'd1) begin
      errors++; $display("FAIL load_use_count got=%0d exp=%0d", StallCount, s0 + 16'd1);
    end
    checks++;
    if (outs !== 7'b111_000_0) begin
      errors++; $display("FAIL load_use_resume got=%b exp=%b", outs, 7'b111_000_0);
    end
    tick();
  endtask

  task automatic test_no_stall();
    logic [15:0] s0;
    s0 = StallCount;
    drive(1'b0, 5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++;
    if (outs !== 7'b111_000_0) begin
      errors++; $display("FAIL no_stall_r0 got=%b exp=%b", outs, 7'b111_000_0);
    end
    tick();
    drive(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    checks++;
    if (outs !== 7'b111_000_0) begin
      errors++; $display("FAIL no_stall_rt_unused got=%b exp=%b", outs, 7'b111_000_0);
    end
    tick();
    idle();
    checks++;
    if (StallCount !== s0) begin
      errors++; $display("FAIL no_stall_count got=%0d exp=%0d", StallCount, s0);
    end
    tick();
  endtask

  task automatic test_branch_priority();
    logic [15:0] s0;
    drive(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    s0 = StallCount;
    checks++;
    if (outs !== 7'b111_110_0) begin
      errors++; $display("FAIL branch_over_load_use got=%b exp=%b", outs, 7'b111_110_0);
    end
    tick();
    idle();
    checks++;
    if (StallCount !== s0) begin
      errors++; $display("FAIL branch_count got=%0d exp=%0d", StallCount, s0);
    end
    tick();
  endtask

  task automatic test_muldiv();
    logic [15:0] s0;
    s0 = StallCount;
    for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
      drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
      checks++;
      if (PCWrite !== (cyc > LAT) || MDBusy !== (cyc >= 2 && cyc <= LAT)) begin
        errors++;
        $display("FAIL muldiv_cycle%0d got pc=%b busy=%b exp pc=%b busy=%b",
                 cyc, PCWrite, MDBusy, cyc > LAT, cyc >= 2 && cyc <= LAT);
      end
      checks++;
      if (outs !== expOuts()) begin
        errors++; $display("FAIL muldiv_model%0d got=%b exp=%b", cyc, outs, expOuts());
      end
      if (cyc == LAT + 1) begin
        checks++;
        if (StallCount !== s0 + 16'(LAT)) begin
          errors++; $display("FAIL muldiv_count got=%0d exp=%0d", StallCount, s0 + 16'(LAT));
        end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_md();
    drive(1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (MDBusy !== 1'b1) begin
      errors++; $display("FAIL mid_md_busy got=%b exp=1", MDBusy);
    end
    #1 rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (outs !== 7'b000_111_0 || StallCount !== 16'd0) begin
      errors++; $display("FAIL mid_md_async_reset got=%b/%0d exp=%b/0", outs, StallCount, 7'b000_111_0);
    end
    tick();
    drive(1'b0, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (outs !== 7'b111_000_0 || StallCount !== 16'd0) begin
      errors++; $display("FAIL mid_md_release got=%b/%0d exp=%b/0", outs, StallCount, 7'b111_000_0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      checks++;
      if (outs !== expOuts()) begin
        errors++; $display("FAIL random_outs i=%0d got=%b exp=%b", i, outs, expOuts());
      end
      checks++;
      if (StallCount !== 16'(mStall)) begin
        errors++; $display("FAIL random_count i=%0d got=%0d exp=%0d", i, StallCount, mStall);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65534; i++) begin
      drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    checks++;
    if (StallCount !== 16'hFFFE) begin
      errors++; $display("FAIL sat_prefill got=%h exp=fffe", StallCount);
    end
    tick();
    drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    checks++;
    if (StallCount !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got=%h exp=ffff", StallCount);
    end
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    checks++;
    if (StallCount !== 16'hFFFF || 16'(mStall) !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got=%h exp=ffff", StallCount);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; Rs1 = '0; Rt1 = '0; UsesRt1 = 1'b0; MemRead2 = 1'b0;
    destreg2 = '0; BranchTaken2 = 1'b0; MulDiv2 = 1'b0;
    modelReset();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_muldiv();
    test_reset_mid_md();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
